// File: rtl/bundle_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : bundle_fetch_queue_if
//  Description : Handshake and status bundle for the fetch-to-decode queue.
//                The slave modport is the queue itself. The master modport is
//                the environment around it: fetch, decode and branch
//                resolution.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bundle_fetch_queue_if #(
  parameter int DEPTH    = 4,
  parameter int BUNDLE_W = 128,
  parameter int PC_W     = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Upstream (fetch) side
  logic                in_valid;
  logic                in_ready;
  logic [BUNDLE_W-1:0] in_bundle;
  logic [PC_W-1:0]     in_pc;

  // Downstream (decode) side
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_ixu1_inst;
  logic [31:0]         out_ixu2_inst;
  logic [31:0]         out_lsu_inst;
  logic [31:0]         out_branch_inst;
  logic [PC_W-1:0]     out_pc;

  // Squash and status
  logic                flush;
  logic [CNT_W-1:0]    count;
  logic [7:0]          flush_drops;

  // Queue side
  modport slave (
    input  in_valid, in_bundle, in_pc, out_ready, flush,
    output in_ready, out_valid, out_ixu1_inst, out_ixu2_inst,
           out_lsu_inst, out_branch_inst, out_pc, count, flush_drops
  );

  // Fetch / decode / branch-unit side
  modport master (
    output in_valid, in_bundle, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_ixu1_inst, out_ixu2_inst,
           out_lsu_inst, out_branch_inst, out_pc, count, flush_drops
  );
endinterface
`default_nettype wire

// File: rtl/bundle_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : bundle_fetch_queue
//  Description : Circular FIFO of PC-tagged VLIW bundles. It decouples
//                instruction fetch from the four decode lanes. The head
//                bundle is split into IXU1/IXU2/LSU/BRANCH slots. A flush
//                empties the queue and counts the discarded entries in a
//                saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module bundle_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int BUNDLE_W = 128,
  parameter int PC_W     = 32
) (
  input  wire                    clk,
  input  wire                    rst,
  bundle_fetch_queue_if.slave    bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = PC_W + BUNDLE_W;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Storage: each entry is {pc, bundle}. It is never reset, because an
  // entry is only read after it has been written.
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_flush_drops;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_enq;
  logic               w_deq;
  logic [ENTRY_W-1:0] w_head;
  logic [8:0]         w_drop_sum;
  logic [7:0]         w_drop_next;

  // Status flags. Both depend only on the registered count, so there is no
  // combinational path from out_ready to in_ready.
  always_comb begin
    w_in_ready  = (r_count != FULL_COUNT);
    w_out_valid = (r_count != '0);
  end

  // Transfer qualifiers. Flush blocks both transfers.
  always_comb begin
    w_enq = bus.in_valid & w_in_ready  & ~bus.flush;
    w_deq = w_out_valid  & bus.out_ready & ~bus.flush;
  end

  // Saturating accumulation of the entries discarded by a flush
  always_comb begin
    w_drop_sum  = {1'b0, r_flush_drops} + 9'(r_count);
    w_drop_next = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  // Bundle write into the tail slot
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= {bus.in_pc, bus.in_bundle};
    end
  end

  // Pointer, occupancy and drop-counter state. Flush has the highest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_flush_drops <= '0;
    end else if (bus.flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_flush_drops <= w_drop_next;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head read. The data is forced to zero while the queue is empty, so
  // unwritten storage never reaches the decode lanes.
  always_comb begin
    w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;
  end

  // Slot split of the head bundle and status outputs
  always_comb begin
    bus.in_ready        = w_in_ready;
    bus.out_valid       = w_out_valid;
    bus.out_pc          = w_head[ENTRY_W-1:BUNDLE_W];
    bus.out_ixu1_inst   = w_head[127:96];
    bus.out_ixu2_inst   = w_head[95:64];
    bus.out_lsu_inst    = w_head[63:32];
    bus.out_branch_inst = w_head[31:0];
    bus.count           = r_count;
    bus.flush_drops     = r_flush_drops;
  end
endmodule
`default_nettype wire
